// File: rtl/ecc_pkg.sv
// ecc_pkg: shared widths, syndrome type and Hamming(12,8) layout constants
package ecc_pkg;
    localparam int CODE_W = 12;
    localparam int DATA_W = 8;
    localparam int P1_IDX = 0;
    localparam int P2_IDX = 1;
    localparam int P4_IDX = 3;
    localparam int P8_IDX = 7;
    localparam int SYN_MAX_VALID = 12;
    typedef logic [3:0] syn_t;
    function automatic logic [DATA_W-1:0] extract_data(input logic [CODE_W-1:0] c);
        return {c[11:8], c[6:4], c[2]};
    endfunction
endpackage

// File: rtl/ecc_syndrome.sv
// ecc_syndrome: combinational 4-bit Hamming syndrome of a 12-bit codeword
module ecc_syndrome import ecc_pkg::*; (
    input  logic [CODE_W-1:0] code,
    output syn_t              syn
);
    assign syn = {code[P8_IDX] ^ code[8] ^ code[9] ^ code[10] ^ code[11],
                  code[P4_IDX] ^ code[4] ^ code[5] ^ code[6] ^ code[11],
                  code[P2_IDX] ^ code[2] ^ code[5] ^ code[6] ^ code[9] ^ code[10],
                  code[P1_IDX] ^ code[2] ^ code[4] ^ code[6] ^ code[8] ^ code[10]};
endmodule

// File: rtl/ecc_decoder.sv
// ecc_decoder: two-stage SEC Hamming(12,8) decoder with valid/ready and saturating error counters
module ecc_decoder import ecc_pkg::*; #(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_corr,
    output logic              out_uncorr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
);
    logic              adv, s1_valid, fix_en, unc, xfer;
    logic [CODE_W-1:0] s1_code, fixed;
    syn_t              syn, s1_syn;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign xfer     = out_valid && out_ready;

    ecc_syndrome u_syn (.code(in_code), .syn(syn));

    assign fix_en = s1_syn != '0 && s1_syn <= syn_t'(SYN_MAX_VALID);
    assign unc    = s1_syn > syn_t'(SYN_MAX_VALID);
    assign fixed  = fix_en ? s1_code ^ (CODE_W'(1) << (s1_syn - syn_t'(1))) : s1_code;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_code    <= '0;
            s1_syn     <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            out_corr   <= 1'b0;
            out_uncorr <= 1'b0;
        end else if (adv) begin
            s1_valid   <= in_valid;
            s1_code    <= in_code;
            s1_syn     <= syn;
            out_valid  <= s1_valid;
            out_data   <= extract_data(fixed);
            out_corr   <= s1_valid && fix_en;
            out_uncorr <= s1_valid && unc;
        end
    end

    // clear (and reset) take priority over a same-cycle increment
    always_ff @(posedge clk) begin
        if (!rst_n || cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else begin
            if (xfer && out_corr && corr_cnt != '1)
                corr_cnt <= corr_cnt + CNT_W'(1);
            if (xfer && out_uncorr && uncorr_cnt != '1)
                uncorr_cnt <= uncorr_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ecc_decoder.sv
// tb_ecc_decoder: directed vector table plus backpressure, saturation, clear and reset sequences
module tb_ecc_decoder;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_corr, out_uncorr, cnt_clr;
    logic [11:0] in_code;
    logic [7:0]  out_data;
    logic [15:0] corr_cnt, uncorr_cnt;

    typedef struct {
        logic [11:0] code;
        logic [7:0]  data;
        logic        corr;
        logic        uncorr;
    } vec_t;

    vec_t vecs[16];
    int   total = 0;
    int   passed = 0;
    int   exp_corr = 0;
    int   exp_uncorr = 0;

    always #5 clk = ~clk;

    ecc_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
        .out_uncorr(out_uncorr), .cnt_clr(cnt_clr), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run_vec(input vec_t v);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = v.code;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("latency[%h]", v.code), n, 2);
        chk($sformatf("data[%h]", v.code), out_data, v.data);
        chk($sformatf("corr[%h]", v.code), out_corr, v.corr);
        chk($sformatf("uncorr[%h]", v.code), out_uncorr, v.uncorr);
        if (v.corr && exp_corr < 65535) exp_corr++;
        if (v.uncorr && exp_uncorr < 65535) exp_uncorr++;
        @(negedge clk);
        chk($sformatf("corr_cnt[%h]", v.code), corr_cnt, exp_corr);
        chk($sformatf("uncorr_cnt[%h]", v.code), uncorr_cnt, exp_uncorr);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] base, bp_code[3], held;
        logic [7:0]  bp_exp[3], got[$];
        int          wi, stall_left, seen;
        bit          acc;
        base = 12'hA27;
        vecs[0] = '{12'hA27, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{12'hA07, 8'hA5, 1'b1, 1'b0};
        vecs[2] = '{12'h226, 8'h25, 1'b0, 1'b1};
        vecs[3] = '{12'hFFF, 8'h7F, 1'b1, 1'b0};
        for (int i = 0; i < 12; i++) vecs[4+i] = '{base ^ (12'h1 << i), 8'hA5, 1'b1, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; in_code = '0; out_ready = 1'b1; cnt_clr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst in_ready", in_ready, 1);
        chk("rst out_valid", out_valid, 0);
        chk("rst out_data", out_data, 0);
        chk("rst out_corr", out_corr, 0);
        chk("rst out_uncorr", out_uncorr, 0);
        chk("rst corr_cnt", corr_cnt, 0);
        chk("rst uncorr_cnt", uncorr_cnt, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i]);

        // backpressure: three back-to-back words, 3-cycle stall on the first output
        bp_code = '{12'h000, 12'hA27, 12'hA07};
        bp_exp  = '{8'h00, 8'hA5, 8'hA5};
        wi = 0; stall_left = 3; held = '0;
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = bp_code[0];
        #1 acc = in_valid && in_ready;
        for (int cyc = 0; cyc < 20 && got.size() < 3; cyc++) begin
            @(negedge clk);
            if (acc) begin
                wi++;
                if (wi < 3) in_code = bp_code[wi];
                else in_valid = 1'b0;
            end
            out_ready = !(out_valid && stall_left > 0);
            #1;
            if (!out_ready) begin
                if (stall_left == 3) held = {4'h0, out_data};
                chk("bp stall in_ready", in_ready, 0);
                chk("bp stall out_data", out_data, held);
                chk("bp stall out_valid", out_valid, 1);
                stall_left--;
            end
            acc = in_valid && in_ready;
            if (out_valid && out_ready) got.push_back(out_data);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("bp count", got.size(), 3);
        for (int i = 0; i < 3; i++) chk($sformatf("bp word%0d", i), (i < got.size()) ? got[i] : 8'hxx, bp_exp[i]);
        exp_corr++;
        repeat (2) @(negedge clk);
        chk("bp corr_cnt", corr_cnt, exp_corr);

        // clear, then saturate corr_cnt
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clr corr_cnt", corr_cnt, 0);
        chk("clr uncorr_cnt", uncorr_cnt, 0);
        exp_corr = 0; exp_uncorr = 0;
        in_valid = 1'b1;
        in_code  = 12'hA07;
        repeat (65535) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        exp_corr = 65535;
        chk("sat preload", corr_cnt, 16'hFFFF);
        run_vec('{12'hA07, 8'hA5, 1'b1, 1'b0});
        chk("sat hold", corr_cnt, 16'hFFFF);

        // clear coinciding with an errored transfer
        run_vec('{12'h226, 8'h25, 1'b0, 1'b1});
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 12'hA07;
        @(negedge clk);
        in_valid = 1'b0;
        seen = 0;
        while (!out_valid && seen < 8) begin
            @(negedge clk);
            seen++;
        end
        chk("clrx out_corr", out_corr, 1);
        cnt_clr = 1'b1;
        @(negedge clk);
        cnt_clr = 1'b0;
        chk("clrx corr_cnt", corr_cnt, 0);
        chk("clrx uncorr_cnt", uncorr_cnt, 0);
        exp_corr = 0; exp_uncorr = 0;

        // reset with two words in flight
        run_vec('{12'hA07, 8'hA5, 1'b1, 1'b0});
        @(negedge clk);
        in_valid = 1'b1;
        in_code  = 12'hA07;
        @(negedge clk);
        in_code  = 12'hA27;
        @(negedge clk);
        in_valid = 1'b0;
        chk("rstm inflight", out_valid, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rstm out_valid", out_valid, 0);
        chk("rstm corr_cnt", corr_cnt, 0);
        chk("rstm uncorr_cnt", uncorr_cnt, 0);
        chk("rstm in_ready", in_ready, 1);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rstm stale", seen, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
